// File: rtl/uvmt_cv32e40s_rvfi_csr_shadow_if.sv
// Bundle between one per-CSR RVFI retirement stream and its shadow monitor.
// The monitor consumes the retirement fields and publishes the shadow state and its error flags.
interface uvmt_cv32e40s_rvfi_csr_shadow_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             rvfi_valid_i;
  logic [63:0]      rvfi_order_i;
  logic [XLEN-1:0]  rvfi_csr_rmask_i;
  logic [XLEN-1:0]  rvfi_csr_wmask_i;
  logic [XLEN-1:0]  rvfi_csr_rdata_i;
  logic [XLEN-1:0]  rvfi_csr_wdata_i;
  logic [XLEN-1:0]  shadow_o;
  logic [XLEN-1:0]  known_o;
  logic             mismatch_o;
  logic [CNT_W-1:0] mismatch_cnt_o;
  logic             err_sticky_o;
  logic             order_err_o;

  modport master (
    output rvfi_valid_i, rvfi_order_i, rvfi_csr_rmask_i, rvfi_csr_wmask_i,
           rvfi_csr_rdata_i, rvfi_csr_wdata_i,
    input  shadow_o, known_o, mismatch_o, mismatch_cnt_o, err_sticky_o, order_err_o
  );

  modport slave (
    input  rvfi_valid_i, rvfi_order_i, rvfi_csr_rmask_i, rvfi_csr_wmask_i,
           rvfi_csr_rdata_i, rvfi_csr_wdata_i,
    output shadow_o, known_o, mismatch_o, mismatch_cnt_o, err_sticky_o, order_err_o
  );
endinterface

// File: rtl/uvmt_cv32e40s_rvfi_csr_shadow.sv
// Shadow copy of one CSR rebuilt from RVFI retirements; flags reads that disagree with known bits.
// Optional rvfi_order gap detection is built when UVMT_RVFI_CSR_SHADOW_ORDER_CHECK_EN is defined.
module uvmt_cv32e40s_rvfi_csr_shadow #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] VOLATILE_MASK = {XLEN{1'b0}},
  parameter int              CNT_W         = 8
) (
  input logic clk_i,
  input logic rst_i,
  uvmt_cv32e40s_rvfi_csr_shadow_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  r_shadow;
  logic [XLEN-1:0]  r_known;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_sticky;
  logic             r_order_err;

  logic [XLEN-1:0]  w_chk;
  logic [XLEN-1:0]  w_learn;
  logic [XLEN-1:0]  w_shadow_nxt;
  logic [XLEN-1:0]  w_known_nxt;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_order_err;

  // Compare against the pre-update shadow; writes take priority over bits learned from rdata.
  always_comb begin
    w_chk        = bus.rvfi_csr_rmask_i & r_known & ~VOLATILE_MASK;
    w_learn      = bus.rvfi_csr_rmask_i & ~r_known & ~bus.rvfi_csr_wmask_i & ~VOLATILE_MASK;
    w_mismatch   = bus.rvfi_valid_i & (|((bus.rvfi_csr_rdata_i ^ r_shadow) & w_chk));
    w_shadow_nxt = (r_shadow & ~bus.rvfi_csr_wmask_i & ~w_learn)
                 | (bus.rvfi_csr_wdata_i & bus.rvfi_csr_wmask_i)
                 | (bus.rvfi_csr_rdata_i & w_learn);
    w_known_nxt  = r_known | ((bus.rvfi_csr_wmask_i | w_learn) & ~VOLATILE_MASK);
    if (w_mismatch && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

`ifdef UVMT_RVFI_CSR_SHADOW_ORDER_CHECK_EN
  logic [63:0] r_last_order;
  logic        r_order_seen;

  // A gap is any order that is not the wrapped successor of the previous retirement.
  always_comb begin
    if (bus.rvfi_valid_i && r_order_seen) begin
      w_order_err = (bus.rvfi_order_i != (r_last_order + 64'd1));
    end else begin
      w_order_err = 1'b0;
    end
  end

  // Order history; cleared by reset so the first retirement afterwards is never flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_order <= 64'd0;
      r_order_seen <= 1'b0;
    end else if (bus.rvfi_valid_i) begin
      r_last_order <= bus.rvfi_order_i;
      r_order_seen <= 1'b1;
    end else begin
      r_last_order <= r_last_order;
      r_order_seen <= r_order_seen;
    end
  end
`else
  logic w_unused_order;

  assign w_unused_order = ^bus.rvfi_order_i;
  assign w_order_err    = 1'b0;
`endif

  // Shadow state and registered flags; pulses last exactly one cycle after the retirement edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shadow     <= {XLEN{1'b0}};
      r_known      <= {XLEN{1'b0}};
      r_mismatch   <= 1'b0;
      r_cnt        <= {CNT_W{1'b0}};
      r_err_sticky <= 1'b0;
      r_order_err  <= 1'b0;
    end else if (bus.rvfi_valid_i) begin
      r_shadow     <= w_shadow_nxt;
      r_known      <= w_known_nxt;
      r_mismatch   <= w_mismatch;
      r_cnt        <= w_cnt_nxt;
      r_err_sticky <= r_err_sticky | w_mismatch | w_order_err;
      r_order_err  <= w_order_err;
    end else begin
      r_mismatch   <= 1'b0;
      r_order_err  <= 1'b0;
    end
  end

  assign bus.shadow_o       = r_shadow;
  assign bus.known_o        = r_known;
  assign bus.mismatch_o     = r_mismatch;
  assign bus.mismatch_cnt_o = r_cnt;
  assign bus.err_sticky_o   = r_err_sticky;
  assign bus.order_err_o    = r_order_err;

endmodule

// File: tb/tb_uvmt_cv32e40s_rvfi_csr_shadow.sv
// Randomized self-checking bench: two monitor instances (default and volatile-bit/2-bit counter)
// fed the same retirement stream and compared each cycle against a per-bit behavioural model.
module tb_uvmt_cv32e40s_rvfi_csr_shadow;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  uvmt_cv32e40s_rvfi_csr_shadow_if #(.XLEN(32), .CNT_W(8)) bus_a ();
  uvmt_cv32e40s_rvfi_csr_shadow_if #(.XLEN(32), .CNT_W(2)) bus_b ();

  uvmt_cv32e40s_rvfi_csr_shadow #(.XLEN(32), .VOLATILE_MASK(32'h0), .CNT_W(8)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_a)
  );
  uvmt_cv32e40s_rvfi_csr_shadow #(.XLEN(32), .VOLATILE_MASK(32'h0000_0080), .CNT_W(2)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_b)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b
  logic [31:0] m_shadow [2];
  logic [31:0] m_known  [2];
  logic        m_mis    [2];
  int          m_cnt    [2];
  logic        m_sticky [2];
  logic        m_oerr   [2];
  logic        m_seen;
  logic [63:0] m_last;
  logic [63:0] g_order;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_shadow[k] = 32'h0; m_known[k] = 32'h0; m_mis[k] = 1'b0;
      m_cnt[k] = 0; m_sticky[k] = 1'b0; m_oerr[k] = 1'b0;
    end
    m_seen = 1'b0;
    m_last = 64'h0;
  endtask

  // Behavioural retirement rule, evaluated bit by bit from the stream's meaning.
  task automatic model_step(input logic valid, input logic [63:0] order, input logic [31:0] rmask,
                            input logic [31:0] wmask, input logic [31:0] rdata, input logic [31:0] wdata);
    logic oerr;
    oerr = 1'b0;
`ifdef UVMT_RVFI_CSR_SHADOW_ORDER_CHECK_EN
    if (valid && m_seen && (order != m_last + 64'd1)) oerr = 1'b1;
    if (valid) begin m_seen = 1'b1; m_last = order; end
`endif
    for (int k = 0; k < 2; k++) begin
      logic [31:0] vol;
      int          cmax;
      logic        mis;
      vol  = (k == 0) ? 32'h0 : 32'h0000_0080;
      cmax = (k == 0) ? 255 : 3;
      mis  = 1'b0;
      if (valid) begin
        for (int b = 0; b < 32; b++) begin
          if (rmask[b] && m_known[k][b] && !vol[b] && (rdata[b] != m_shadow[k][b])) mis = 1'b1;
        end
        for (int b = 0; b < 32; b++) begin
          if (wmask[b]) begin
            m_shadow[k][b] = wdata[b];
            if (!vol[b]) m_known[k][b] = 1'b1;
          end else if (rmask[b] && !m_known[k][b] && !vol[b]) begin
            m_shadow[k][b] = rdata[b];
            m_known[k][b]  = 1'b1;
          end
        end
        if (mis && m_cnt[k] < cmax) m_cnt[k]++;
        m_sticky[k] = m_sticky[k] | mis | oerr;
        m_oerr[k]   = oerr;
      end else begin
        m_oerr[k] = 1'b0;
      end
      m_mis[k] = mis;
    end
  endtask

  task automatic compare_all();
    check_eq("a_shadow", bus_a.shadow_o, m_shadow[0]);
    check_eq("a_known", bus_a.known_o, m_known[0]);
    check_eq("a_mismatch", bus_a.mismatch_o, m_mis[0]);
    check_eq("a_cnt", bus_a.mismatch_cnt_o, m_cnt[0]);
    check_eq("a_sticky", bus_a.err_sticky_o, m_sticky[0]);
    check_eq("a_order_err", bus_a.order_err_o, m_oerr[0]);
    check_eq("b_shadow", bus_b.shadow_o, m_shadow[1]);
    check_eq("b_known", bus_b.known_o, m_known[1]);
    check_eq("b_mismatch", bus_b.mismatch_o, m_mis[1]);
    check_eq("b_cnt", bus_b.mismatch_cnt_o, m_cnt[1]);
    check_eq("b_sticky", bus_b.err_sticky_o, m_sticky[1]);
    check_eq("b_order_err", bus_b.order_err_o, m_oerr[1]);
  endtask

  task automatic step(input logic valid, input logic [63:0] order, input logic [31:0] rmask,
                      input logic [31:0] wmask, input logic [31:0] rdata, input logic [31:0] wdata);
    @(negedge clk_i);
    bus_a.rvfi_valid_i = valid;  bus_b.rvfi_valid_i = valid;
    bus_a.rvfi_order_i = order;  bus_b.rvfi_order_i = order;
    bus_a.rvfi_csr_rmask_i = rmask; bus_b.rvfi_csr_rmask_i = rmask;
    bus_a.rvfi_csr_wmask_i = wmask; bus_b.rvfi_csr_wmask_i = wmask;
    bus_a.rvfi_csr_rdata_i = rdata; bus_b.rvfi_csr_rdata_i = rdata;
    bus_a.rvfi_csr_wdata_i = wdata; bus_b.rvfi_csr_wdata_i = wdata;
    @(posedge clk_i);
    model_step(valid, order, rmask, wmask, rdata, wdata);
    #1;
    compare_all();
  endtask

  // Retire one instruction with the next consecutive order number.
  task automatic retire(input logic [31:0] rmask, input logic [31:0] wmask,
                        input logic [31:0] rdata, input logic [31:0] wdata);
    step(1'b1, g_order, rmask, wmask, rdata, wdata);
    g_order = g_order + 64'd1;
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus_a.rvfi_valid_i = 1'b0; bus_b.rvfi_valid_i = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  int exp_sat [5] = '{1, 2, 3, 3, 3};

  initial begin
    bus_a.rvfi_valid_i = 1'b0; bus_b.rvfi_valid_i = 1'b0;
    bus_a.rvfi_order_i = 64'h0; bus_b.rvfi_order_i = 64'h0;
    bus_a.rvfi_csr_rmask_i = 32'h0; bus_b.rvfi_csr_rmask_i = 32'h0;
    bus_a.rvfi_csr_wmask_i = 32'h0; bus_b.rvfi_csr_wmask_i = 32'h0;
    bus_a.rvfi_csr_rdata_i = 32'h0; bus_b.rvfi_csr_rdata_i = 32'h0;
    bus_a.rvfi_csr_wdata_i = 32'h0; bus_b.rvfi_csr_wdata_i = 32'h0;
    g_order = 64'd0;
    model_reset();
    do_reset();

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) idle();

    // Full write then matching read
    retire(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678);
    retire(32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h0);
    check_eq("s2_known", bus_a.known_o, 64'hFFFF_FFFF);
    check_eq("s2_shadow", bus_a.shadow_o, 64'h1234_5678);
    check_eq("s2_no_mismatch", bus_a.mismatch_o, 64'h0);

    // Read disagreeing in one known bit
    retire(32'hFFFF_FFFF, 32'h0, 32'h1234_5679, 32'h0);
    check_eq("s3_mismatch", bus_a.mismatch_o, 64'h1);
    check_eq("s3_cnt", bus_a.mismatch_cnt_o, 64'h1);
    check_eq("s3_sticky", bus_a.err_sticky_o, 64'h1);
    idle();
    check_eq("s3_pulse_drop", bus_a.mismatch_o, 64'h0);
    check_eq("s3_sticky_hold", bus_a.err_sticky_o, 64'h1);

    // Volatile bit 7 never becomes known and never mismatches
    do_reset();
    retire(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_00FF);
    retire(32'hFFFF_FFFF, 32'h0, 32'h0000_007F, 32'h0);
    check_eq("s4_no_mismatch", bus_b.mismatch_o, 64'h0);
    check_eq("s4_known", bus_b.known_o, 64'hFFFF_FF7F);

    // Saturation of the 2-bit counter
    do_reset();
    retire(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      retire(32'hFFFF_FFFF, 32'h0, 32'h0000_0100 << i, 32'h0);
      check_eq("s5_cnt_sat", bus_b.mismatch_cnt_o, exp_sat[i]);
    end

    // Order gap, then reset mid-stream with an unrelated order next
    do_reset();
    step(1'b1, 64'd5, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 64'd6, 32'h0, 32'h0, 32'h0, 32'h0);
    check_eq("s6_no_err", bus_a.order_err_o, 64'h0);
    step(1'b1, 64'd8, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef UVMT_RVFI_CSR_SHADOW_ORDER_CHECK_EN
    check_eq("s6_gap_err", bus_a.order_err_o, 64'h1);
`else
    check_eq("s6_tied_off", bus_a.order_err_o, 64'h0);
`endif
    idle();
    check_eq("s6_pulse_drop", bus_a.order_err_o, 64'h0);
    do_reset();
    step(1'b1, 64'd20, 32'h0, 32'h0, 32'h0, 32'h0);
    check_eq("s6_after_reset", bus_a.order_err_o, 64'h0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 64'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_eq("s6_wrap_ok", bus_a.order_err_o, 64'h0);

    // Randomized stream, mostly consistent reads with occasional corruption, gaps and resets
    do_reset();
    g_order = {32'h0, $urandom};
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rm, wm, rd, wd;
      int          sel;
      if (i % 400 == 399) do_reset();
      sel = $urandom_range(0, 3);
      rm  = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      sel = $urandom_range(0, 3);
      wm  = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      wd  = $urandom;
      rd  = (m_known[0] & m_shadow[0]) | (~m_known[0] & $urandom);
      if ($urandom_range(0, 7) == 0) rd = rd ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 19) == 0) g_order = g_order + 64'd2;
        retire(rm, wm, rd, wd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
